// File: rtl/sprite_motion_engine_if.sv
// Command channel into the sprite motion engine: one spawn/kill request per handshake.
interface sprite_motion_engine_if #(
    parameter int unsigned ID_W      = 2,
    parameter int unsigned X_WIDTH   = 11,
    parameter int unsigned Y_WIDTH   = 10,
    parameter int unsigned VEL_WIDTH = 4
) ();
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [ID_W-1:0]      cmd_id;
    logic                 cmd_kill;
    logic [X_WIDTH-1:0]   cmd_x;
    logic [Y_WIDTH-1:0]   cmd_y;
    logic [VEL_WIDTH-1:0] cmd_vx;
    logic [VEL_WIDTH-1:0] cmd_vy;

    modport master (
        output cmd_valid, cmd_id, cmd_kill, cmd_x, cmd_y, cmd_vx, cmd_vy,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_id, cmd_kill, cmd_x, cmd_y, cmd_vx, cmd_vy,
        output cmd_ready
    );
endinterface

// File: rtl/sprite_motion_engine.sv
// Per-frame sprite state engine: moves/bounces/animates N channels once per
// video frame and publishes the whole set atomically to the graphics stage.
module sprite_motion_engine #(
    parameter int unsigned NUM_SPRITES = 4,
    parameter int unsigned X_WIDTH     = 11,
    parameter int unsigned Y_WIDTH     = 10,
    parameter int unsigned VEL_WIDTH   = 4,
    parameter int unsigned SCREEN_W    = 1280,
    parameter int unsigned SCREEN_H    = 720,
    parameter int unsigned SPRITE_W    = 192,
    parameter int unsigned SPRITE_H    = 128,
    parameter int unsigned NUM_FRAMES  = 5,
    parameter int unsigned FRAME_DIV   = 6,
    localparam int unsigned ID_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
    localparam int unsigned FN_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic                           clk_pixel,
    input  logic                           sys_rst_n,
    input  logic                           new_frame,
    sprite_motion_engine_if.slave          cmd,
    output logic [NUM_SPRITES-1:0]         sprite_valid,
    output logic [NUM_SPRITES*X_WIDTH-1:0] sprite_x,
    output logic [NUM_SPRITES*Y_WIDTH-1:0] sprite_y,
    output logic [NUM_SPRITES*FN_W-1:0]    sprite_frame_number,
    output logic                           busy,
    output logic                           overrun
);
    localparam int unsigned X_MAX = SCREEN_W - SPRITE_W;
    localparam int unsigned Y_MAX = SCREEN_H - SPRITE_H;
    localparam int unsigned DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int unsigned XS_W  = X_WIDTH + 2;
    localparam int unsigned YS_W  = Y_WIDTH + 2;
    localparam logic [VEL_WIDTH-1:0] VEL_MIN = VEL_WIDTH'(1) << (VEL_WIDTH - 1);
    localparam logic [VEL_WIDTH-1:0] VEL_SAT = VEL_MIN | VEL_WIDTH'(1);

    typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_PUBLISH} state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] idx_q, idx_d;

    logic [NUM_SPRITES-1:0]      w_valid;
    logic [X_WIDTH-1:0]          w_x     [NUM_SPRITES];
    logic [Y_WIDTH-1:0]          w_y     [NUM_SPRITES];
    logic signed [VEL_WIDTH-1:0] w_vx    [NUM_SPRITES];
    logic signed [VEL_WIDTH-1:0] w_vy    [NUM_SPRITES];
    logic [FN_W-1:0]             w_frame [NUM_SPRITES];
    logic [DIV_W-1:0]            w_div   [NUM_SPRITES];

    logic signed [XS_W-1:0]      sx;
    logic signed [YS_W-1:0]      sy;
    logic [X_WIDTH-1:0]          nx;
    logic [Y_WIDTH-1:0]          ny;
    logic signed [VEL_WIDTH-1:0] nvx, nvy;
    logic [FN_W-1:0]             nframe;
    logic [DIV_W-1:0]            ndiv;
    logic                        cmd_hit;

    // The most-negative velocity has no positive mirror, so clip it by one.
    function automatic logic [VEL_WIDTH-1:0] sat_vel(input logic [VEL_WIDTH-1:0] v);
        return (v == VEL_MIN) ? VEL_SAT : v;
    endfunction

    assign cmd.cmd_ready = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign cmd_hit       = (state_q == S_IDLE) && cmd.cmd_valid
                           && (32'(cmd.cmd_id) < NUM_SPRITES);

    // State and channel index register.
    always_ff @(posedge clk_pixel or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Frame sequencing: IDLE -> one UPDATE cycle per channel -> PUBLISH.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (new_frame) begin
                    state_d = S_UPDATE;
                    idx_d   = '0;
                end
            end
            S_UPDATE: begin
                idx_d = idx_q + ID_W'(1);
                if (idx_q == ID_W'(NUM_SPRITES - 1)) begin
                    state_d = S_PUBLISH;
                    idx_d   = '0;
                end
            end
            S_PUBLISH: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Next motion and animation values for the channel under update.
    always_comb begin
        sx     = signed'({2'b00, w_x[idx_q]}) + XS_W'(w_vx[idx_q]);
        sy     = signed'({2'b00, w_y[idx_q]}) + YS_W'(w_vy[idx_q]);
        nx     = X_WIDTH'(sx);
        ny     = Y_WIDTH'(sy);
        nvx    = w_vx[idx_q];
        nvy    = w_vy[idx_q];
        nframe = w_frame[idx_q];
        ndiv   = w_div[idx_q] + DIV_W'(1);
        if (sx < 0) begin
            nx  = '0;
            nvx = -w_vx[idx_q];
        end else if (sx > signed'(XS_W'(X_MAX))) begin
            nx  = X_WIDTH'(X_MAX);
            nvx = -w_vx[idx_q];
        end
        if (sy < 0) begin
            ny  = '0;
            nvy = -w_vy[idx_q];
        end else if (sy > signed'(YS_W'(Y_MAX))) begin
            ny  = Y_WIDTH'(Y_MAX);
            nvy = -w_vy[idx_q];
        end
        if (w_div[idx_q] == DIV_W'(FRAME_DIV - 1)) begin
            ndiv   = '0;
            nframe = (w_frame[idx_q] == FN_W'(NUM_FRAMES - 1)) ? '0
                                                               : w_frame[idx_q] + FN_W'(1);
        end
    end

    // Working register set: command writes in IDLE, per-channel steps in UPDATE.
    always_ff @(posedge clk_pixel or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            w_valid <= '0;
            for (int i = 0; i < int'(NUM_SPRITES); i++) begin
                w_x[i]     <= '0;
                w_y[i]     <= '0;
                w_vx[i]    <= '0;
                w_vy[i]    <= '0;
                w_frame[i] <= '0;
                w_div[i]   <= '0;
            end
        end else begin
            if (cmd_hit) begin
                if (cmd.cmd_kill) begin
                    w_valid[cmd.cmd_id] <= 1'b0;
                end else begin
                    w_valid[cmd.cmd_id] <= 1'b1;
                    w_x[cmd.cmd_id]     <= (cmd.cmd_x > X_WIDTH'(X_MAX)) ? X_WIDTH'(X_MAX) : cmd.cmd_x;
                    w_y[cmd.cmd_id]     <= (cmd.cmd_y > Y_WIDTH'(Y_MAX)) ? Y_WIDTH'(Y_MAX) : cmd.cmd_y;
                    w_vx[cmd.cmd_id]    <= sat_vel(cmd.cmd_vx);
                    w_vy[cmd.cmd_id]    <= sat_vel(cmd.cmd_vy);
                    w_frame[cmd.cmd_id] <= '0;
                    w_div[cmd.cmd_id]   <= '0;
                end
            end
            if ((state_q == S_UPDATE) && w_valid[idx_q]) begin
                w_x[idx_q]     <= nx;
                w_y[idx_q]     <= ny;
                w_vx[idx_q]    <= nvx;
                w_vy[idx_q]    <= nvy;
                w_frame[idx_q] <= nframe;
                w_div[idx_q]   <= ndiv;
            end
        end
    end

    // Published set: copied from the working set in a single PUBLISH edge.
    always_ff @(posedge clk_pixel or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sprite_valid        <= '0;
            sprite_x            <= '0;
            sprite_y            <= '0;
            sprite_frame_number <= '0;
        end else if (state_q == S_PUBLISH) begin
            sprite_valid <= w_valid;
            for (int i = 0; i < int'(NUM_SPRITES); i++) begin
                sprite_x[i*X_WIDTH +: X_WIDTH]         <= w_x[i];
                sprite_y[i*Y_WIDTH +: Y_WIDTH]         <= w_y[i];
                sprite_frame_number[i*FN_W +: FN_W]    <= w_frame[i];
            end
        end
    end

    // Sticky flag for a frame pulse that arrived before the previous pass finished.
    always_ff @(posedge clk_pixel or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            overrun <= 1'b0;
        end else if (new_frame && (state_q != S_IDLE)) begin
            overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sprite_motion_engine.sv
// Randomised plus directed bench for sprite_motion_engine against an integer model.
module tb_sprite_motion_engine;
    localparam int N     = 4;
    localparam int XW    = 11;
    localparam int YW    = 10;
    localparam int VW    = 4;
    localparam int FNW   = 3;
    localparam int X_MAX = 1280 - 192;
    localparam int Y_MAX = 720 - 128;
    localparam int NFR   = 5;
    localparam int FDIV  = 6;

    logic              clk_pixel;
    logic              sys_rst_n;
    logic              new_frame;
    logic [N-1:0]      sprite_valid;
    logic [N*XW-1:0]   sprite_x;
    logic [N*YW-1:0]   sprite_y;
    logic [N*FNW-1:0]  sprite_frame_number;
    logic              busy;
    logic              overrun;

    sprite_motion_engine_if #(.ID_W(2), .X_WIDTH(XW), .Y_WIDTH(YW), .VEL_WIDTH(VW)) cmd_if ();

    sprite_motion_engine dut (
        .clk_pixel           (clk_pixel),
        .sys_rst_n           (sys_rst_n),
        .new_frame           (new_frame),
        .cmd                 (cmd_if),
        .sprite_valid        (sprite_valid),
        .sprite_x            (sprite_x),
        .sprite_y            (sprite_y),
        .sprite_frame_number (sprite_frame_number),
        .busy                (busy),
        .overrun             (overrun)
    );

    initial clk_pixel = 1'b0;
    always #5 clk_pixel = ~clk_pixel;

    int vectors = 0;
    int miscompares = 0;

    // Model: working (m_*) and published (p_*) state as plain integers.
    int m_valid [N], m_x [N], m_y [N], m_vx [N], m_vy [N], m_fr [N], m_div [N];
    int p_valid [N], p_x [N], p_y [N], p_fr [N];
    int m_overrun;
    int c_id, c_kill, c_x, c_y, c_vx, c_vy;

    task automatic check(input string tag, input longint got, input longint exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk_pixel);
        #1;
    endtask

    function automatic int to_vel(input int raw);
        int v;
        v = (raw >= 8) ? raw - 16 : raw;
        return (v == -8) ? -7 : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0; m_x[i] = 0; m_y[i] = 0; m_vx[i] = 0; m_vy[i] = 0;
            m_fr[i] = 0; m_div[i] = 0;
            p_valid[i] = 0; p_x[i] = 0; p_y[i] = 0; p_fr[i] = 0;
        end
        m_overrun = 0;
    endtask

    task automatic model_accept();
        if (c_kill != 0) begin
            m_valid[c_id] = 0;
        end else begin
            m_valid[c_id] = 1;
            m_x[c_id]  = (c_x > X_MAX) ? X_MAX : c_x;
            m_y[c_id]  = (c_y > Y_MAX) ? Y_MAX : c_y;
            m_vx[c_id] = to_vel(c_vx);
            m_vy[c_id] = to_vel(c_vy);
            m_fr[c_id] = 0;
            m_div[c_id] = 0;
        end
    endtask

    task automatic model_frame();
        int s;
        for (int i = 0; i < N; i++) begin
            if (m_valid[i] != 0) begin
                s = m_x[i] + m_vx[i];
                if (s < 0) begin m_x[i] = 0; m_vx[i] = -m_vx[i]; end
                else if (s > X_MAX) begin m_x[i] = X_MAX; m_vx[i] = -m_vx[i]; end
                else m_x[i] = s;
                s = m_y[i] + m_vy[i];
                if (s < 0) begin m_y[i] = 0; m_vy[i] = -m_vy[i]; end
                else if (s > Y_MAX) begin m_y[i] = Y_MAX; m_vy[i] = -m_vy[i]; end
                else m_y[i] = s;
                if (m_div[i] == FDIV - 1) begin
                    m_div[i] = 0;
                    m_fr[i] = (m_fr[i] + 1) % NFR;
                end else begin
                    m_div[i]++;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            p_valid[i] = m_valid[i]; p_x[i] = m_x[i]; p_y[i] = m_y[i]; p_fr[i] = m_fr[i];
        end
    endtask

    task automatic drive_cmd(input int id, input int kill, input int x, input int y,
                             input int vx, input int vy);
        c_id = id; c_kill = kill; c_x = x; c_y = y; c_vx = vx; c_vy = vy;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_id    = 2'(id);
        cmd_if.cmd_kill  = (kill != 0);
        cmd_if.cmd_x     = XW'(x);
        cmd_if.cmd_y     = YW'(y);
        cmd_if.cmd_vx    = VW'(vx);
        cmd_if.cmd_vy    = VW'(vy);
    endtask

    task automatic send_cmd(input int id, input int kill, input int x, input int y,
                            input int vx, input int vy);
        drive_cmd(id, kill, x, y, vx, vy);
        check("ready_idle", longint'(cmd_if.cmd_ready), 1);
        cycle();
        cmd_if.cmd_valid = 1'b0;
        model_accept();
    endtask

    task automatic check_outputs();
        for (int i = 0; i < N; i++) begin
            check($sformatf("valid%0d", i), longint'(sprite_valid[i]), p_valid[i]);
            check($sformatf("x%0d", i), longint'(sprite_x[i*XW +: XW]), p_x[i]);
            check($sformatf("y%0d", i), longint'(sprite_y[i*YW +: YW]), p_y[i]);
            check($sformatf("frame%0d", i), longint'(sprite_frame_number[i*FNW +: FNW]), p_fr[i]);
        end
        check("busy_idle", longint'(busy), 0);
        check("overrun", longint'(overrun), m_overrun);
    endtask

    // One frame pass; optional command in the pulse cycle and optional stray pulse at t+2.
    task automatic run_frame(input bit with_cmd, input bit extra);
        int n;
        new_frame = 1'b1;
        check("ready_pulse", longint'(cmd_if.cmd_ready), 1);
        cycle();
        new_frame = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        if (with_cmd) model_accept();
        n = 1;
        check("busy_t1", longint'(busy), 1);
        if (extra) begin
            cycle(); n++;
            new_frame = 1'b1;
            cycle(); n++;
            new_frame = 1'b0;
            m_overrun = 1;
            check("overrun_set", longint'(overrun), 1);
        end
        while (busy && n < 50) begin
            cycle();
            n++;
        end
        check("frame_latency", n, N + 2);
        model_frame();
        check_outputs();
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        cycle();
        cycle();
        sys_rst_n = 1'b1;
        model_reset();
        cycle();
    endtask

    initial begin
        int w;
        sys_rst_n = 1'b0;
        new_frame = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_id = '0;
        cmd_if.cmd_kill = 1'b0;
        cmd_if.cmd_x = '0;
        cmd_if.cmd_y = '0;
        cmd_if.cmd_vx = '0;
        cmd_if.cmd_vy = '0;
        model_reset();
        #2;
        do_reset();
        check_outputs();
        check("ready_reset", longint'(cmd_if.cmd_ready), 1);

        // Basic move of channel 0.
        send_cmd(0, 0, 100, 200, 3, 14);
        run_frame(1'b0, 1'b0);
        check("dir_x0", longint'(sprite_x[0 +: XW]), 103);
        check("dir_y0", longint'(sprite_y[0 +: YW]), 198);
        check("dir_v1", longint'(sprite_valid[1]), 0);

        // Right/bottom bounce on ch1, left/top bounce on ch2.
        send_cmd(1, 0, 1087, 590, 5, 4);
        send_cmd(2, 0, 2, 1, 11, 13);
        run_frame(1'b0, 1'b0);
        check("rb_x1_f1", longint'(sprite_x[XW +: XW]), 1088);
        check("rb_y1_f1", longint'(sprite_y[YW +: YW]), 592);
        check("lt_x2_f1", longint'(sprite_x[2*XW +: XW]), 0);
        run_frame(1'b0, 1'b0);
        check("rb_x1_f2", longint'(sprite_x[XW +: XW]), 1083);
        check("rb_y1_f2", longint'(sprite_y[YW +: YW]), 588);
        check("lt_x2_f2", longint'(sprite_x[2*XW +: XW]), 5);

        // Spawn clamp and most-negative velocity saturation.
        send_cmd(3, 0, 2000, 1000, 8, 0);
        run_frame(1'b0, 1'b0);
        check("clamp_x3", longint'(sprite_x[3*XW +: XW]), 1081);
        check("clamp_y3", longint'(sprite_y[3*YW +: YW]), 592);

        // Command held while busy is taken on the first IDLE cycle.
        new_frame = 1'b1;
        cycle();
        new_frame = 1'b0;
        drive_cmd(2, 1, 0, 0, 0, 0);
        w = 0;
        while (!cmd_if.cmd_ready && w < 50) begin
            check("ready_busy", longint'(cmd_if.cmd_ready), 0);
            cycle();
            w++;
        end
        check("hold_wait", w, N + 1);
        model_frame();
        cycle();
        cmd_if.cmd_valid = 1'b0;
        model_accept();
        check_outputs();
        run_frame(1'b0, 1'b0);
        check("kill_v2", longint'(sprite_valid[2]), 0);

        // Spawn and frame pulse in the same cycle.
        drive_cmd(1, 0, 500, 300, 2, 15);
        run_frame(1'b1, 1'b0);
        check("sim_x1", longint'(sprite_x[XW +: XW]), 502);
        check("sim_y1", longint'(sprite_y[YW +: YW]), 299);

        // Animation cadence on a stationary sprite.
        do_reset();
        send_cmd(0, 0, 10, 10, 0, 0);
        for (int f = 1; f <= 30; f++) begin
            run_frame(1'b0, 1'b0);
            if (f == 6) check("anim_f6", longint'(sprite_frame_number[0 +: FNW]), 1);
        end
        check("anim_f30", longint'(sprite_frame_number[0 +: FNW]), 0);
        check("anim_idle1", longint'(sprite_frame_number[FNW +: FNW]), 0);

        // Stray pulse mid-update, then reset mid-update.
        run_frame(1'b0, 1'b1);
        new_frame = 1'b1;
        cycle();
        new_frame = 1'b0;
        cycle();
        cycle();
        sys_rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        check("rst_valid", longint'(sprite_valid), 0);
        cycle();
        sys_rst_n = 1'b1;
        cycle();
        check("ready_after_rst", longint'(cmd_if.cmd_ready), 1);

        // Randomised commands and frames.
        for (int it = 0; it < 60; it++) begin
            int ncmd;
            ncmd = int'($urandom_range(0, 3));
            for (int k = 0; k < ncmd; k++) begin
                send_cmd(int'($urandom_range(0, N - 1)), ($urandom_range(0, 3) == 0) ? 1 : 0,
                         int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)),
                         int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            end
            if ($urandom_range(0, 3) == 0) begin
                drive_cmd(int'($urandom_range(0, N - 1)), 0,
                          int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)),
                          int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
                run_frame(1'b1, $urandom_range(0, 7) == 0);
            end else begin
                run_frame(1'b0, $urandom_range(0, 7) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sprite_motion_engine.md
# sprite_motion_engine

Per-frame sprite state engine sitting between `video_sig_gen` and `graphics`. It replaces hard-wired sprite constants with `NUM_SPRITES` independent channels. Each channel holds position, signed velocity and an animation frame counter. On every `new_frame` pulse a state machine steps through the channels one per cycle, applies motion with edge bounce, advances animation, then publishes all channels atomically so `graphics` never sees a half-updated set.

## Interface
Parameters:
- `NUM_SPRITES`, 4: channel count (≥1).
- `X_WIDTH`, 11: x coordinate width.
- `Y_WIDTH`, 10: y coordinate width.
- `VEL_WIDTH`, 4: signed velocity width (px/frame).
- `SCREEN_W`, 1280: active width.
- `SCREEN_H`, 720: active height.
- `SPRITE_W`, 192: sprite width.
- `SPRITE_H`, 128: sprite height.
- `NUM_FRAMES`, 5: animation frames per sprite.
- `FRAME_DIV`, 6: video frames per animation step (≥1).
- Derived: `ID_W = max(1,$clog2(NUM_SPRITES))`, `FN_W = max(1,$clog2(NUM_FRAMES))`, `X_MAX = SCREEN_W-SPRITE_W`, `Y_MAX = SCREEN_H-SPRITE_H`.

Ports:
- `clk_pixel`  in  1  pixel clock; sole clock.
- `sys_rst_n`  in  1  reset, asynchronous, active-low.
- `new_frame`  in  1  one-cycle pulse per video frame.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`.
- `cmd_id`  in  ID_W  target channel.
- `cmd_kill`  in  1  1 = deactivate channel, 0 = spawn/overwrite.
- `cmd_x`  in  X_WIDTH  spawn x.
- `cmd_y`  in  Y_WIDTH  spawn y.
- `cmd_vx`  in  VEL_WIDTH  spawn x velocity, signed.
- `cmd_vy`  in  VEL_WIDTH  spawn y velocity, signed.
- `sprite_valid`  out  NUM_SPRITES  published active flags.
- `sprite_x`  out  NUM_SPRITES*X_WIDTH  published x; channel i at `[i*X_WIDTH +: X_WIDTH]`.
- `sprite_y`  out  NUM_SPRITES*Y_WIDTH  published y.
- `sprite_frame_number`  out  NUM_SPRITES*FN_W  published animation frame.
- `busy`  out  1  state ≠ IDLE.
- `overrun`  out  1  sticky: `new_frame` arrived while busy.

## Operation
- Two register sets:
  - working: valid, x, y, vx, vy, frame, div per channel.
  - published: drives `sprite_*`.
- States:
  - IDLE: `cmd_ready=1`.
    - On accept with `cmd_kill=1`: working valid[id]=0; other fields unchanged.
    - On accept with `cmd_kill=0`: valid=1; x=min(cmd_x,X_MAX); y=min(cmd_y,Y_MAX); vx, vy loaded, with the most-negative value saturated to −(2^(VEL_WIDTH−1)−1); frame=0; div=0.
    - `new_frame` → UPDATE with idx=0.
  - UPDATE: `cmd_ready=0`. Processes channel idx; idx increments; after idx=NUM_SPRITES−1 → PUBLISH. Invalid channels are skipped unchanged (still one cycle each).
  - PUBLISH: copy all working fields to published in one edge → IDLE.
- Motion per axis, shown for x:
  - s = {0,x} + sext(vx), computed signed at X_WIDTH+2 bits.
  - s<0: x=0, vx=−vx.
  - s>X_MAX: x=X_MAX, vx=−vx.
  - else x=s.
  - vx=0 never bounces. y is handled identically with Y_MAX.
- Animation: if div==FRAME_DIV−1, then div=0 and frame=(frame==NUM_FRAMES−1)?0:frame+1; else div++.
- `cmd_valid` and `new_frame` in the same IDLE cycle: the command is written first; UPDATE then sees the new values.
- `new_frame` while busy: ignored for sequencing; sets `overrun`=1, which clears only on reset.
- Same channel commanded repeatedly: last accepted command wins.

## Timing
- Reset (async assert on `sys_rst_n`=0): state IDLE; all working and published registers 0; `sprite_valid`=0, `sprite_x/y/frame_number`=0, `busy`=0, `overrun`=0, `cmd_ready`=1 after deassert.
- Reset asserted mid-UPDATE: immediate clear; no partial publish.
- `new_frame` high in IDLE at cycle t:
  - UPDATE during cycles t+1 … t+N, where N=NUM_SPRITES.
  - PUBLISH at t+N+1.
  - New outputs and IDLE from t+N+2.
  - `busy` is high during t+1 … t+N+1.
- A command accepted at cycle t appears on outputs only after the next PUBLISH.
- `cmd_ready` is combinational from state; all `sprite_*` outputs are registered and change only on the PUBLISH edge or reset.

## Test plan
- Reset; spawn id0 with x=100, y=200, vx=3, vy=−2; pulse `new_frame` → at t+6 (N=4): `sprite_valid`[0]=1, x0=103, y0=198, frame0=0; other channels valid=0.
- Right bounce: spawn x=1087, vx=5; frame 1 → x=1088; frame 2 → x=1083. Bottom: y=590, vy=4 → y=592, then y=588.
- Left/top bounce: x=2, vx=−5 → 0, then 5. Spawn with vx=−8 (VEL_WIDTH=4) → stored as −7. Spawn with cmd_x=2000 → x=1088.
- Animation: 6 `new_frame` pulses → frame=1; 30 pulses → frame=0; inactive channel frame stays 0.
- Handshake:
  - `cmd_valid` held (kill id2) while busy: `cmd_ready`=0 until IDLE, accepted on the first IDLE cycle; valid[2]=0 after the next publish.
  - Simultaneous spawn and `new_frame` in IDLE → spawned sprite published already moved by one step.
- `new_frame` at t+2 mid-UPDATE → `overrun`=1, publish still at t+N+1. Assert `sys_rst_n`=0 at t+3 → all outputs 0 immediately, `busy`=0.
